// File: rtl/axi4_stream_arb_pkg.sv
// rtl/axi4_stream_arb_pkg.sv - shared state type and source limit for the stream arbiter
package axi4_stream_arb_pkg;

    localparam int MAX_SRC = 16;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational rotate-priority selector, search starts after last_grant
module rr_arbiter #(
    parameter int NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0]         req,
    input  logic [$clog2(NUM_SRC)-1:0] last_grant,
    output logic [$clog2(NUM_SRC)-1:0] gnt_idx,
    output logic                       gnt_valid
);

    localparam int IW = $clog2(NUM_SRC);

    always_comb begin
        int            cand;
        logic [IW-1:0] cand_idx;
        cand      = 0;
        cand_idx  = '0;
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        // i runs 1..NUM_SRC so the previous owner is tried last
        for (int i = 1; i <= NUM_SRC; i++) begin
            cand     = (int'(last_grant) + i) % NUM_SRC;
            cand_idx = IW'(cand);
            if (!gnt_valid && req[cand_idx]) begin
                gnt_valid = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

endmodule

// File: rtl/axi4_stream_arbiter.sv
// rtl/axi4_stream_arbiter.sv - packet-locked round-robin N:1 stream arbiter
module axi4_stream_arbiter
    import axi4_stream_arb_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int N       = 1,
    parameter int I       = 1,
    parameter int D       = 1,
    parameter int U       = 1
) (
    input  logic                            ACLK,
    input  logic                            ARESET,
    input  logic [NUM_SRC-1:0]              s_TVALID,
    input  logic [NUM_SRC-1:0]              s_TLAST,
    output logic [NUM_SRC-1:0]              s_TREADY,
    input  logic [NUM_SRC-1:0][8*N-1:0]     s_TDATA,
    input  logic [NUM_SRC-1:0][N-1:0]       s_TSTRB,
    input  logic [NUM_SRC-1:0][N-1:0]       s_TKEEP,
    input  logic [NUM_SRC-1:0][I-1:0]       s_TID,
    input  logic [NUM_SRC-1:0][D-1:0]       s_TDEST,
    input  logic [NUM_SRC-1:0][U-1:0]       s_TUSER,
    output logic                            m_TVALID,
    output logic [8*N-1:0]                  m_TDATA,
    output logic [N-1:0]                    m_TSTRB,
    output logic [N-1:0]                    m_TKEEP,
    output logic                            m_TLAST,
    output logic [I-1:0]                    m_TID,
    output logic [D-1:0]                    m_TDEST,
    output logic [U-1:0]                    m_TUSER,
    input  logic                            m_TREADY,
    output logic [$clog2(NUM_SRC)-1:0]      grant_idx,
    output logic                            busy
);

    localparam int IW = $clog2(NUM_SRC);

    arb_state_t    state;
    logic [IW-1:0] last_grant;
    logic [IW-1:0] arb_idx;
    logic          arb_valid;
    logic          locked;

    rr_arbiter #(
        .NUM_SRC (NUM_SRC)
    ) u_rr_arbiter (
        .req        (s_TVALID),
        .last_grant (last_grant),
        .gnt_idx    (arb_idx),
        .gnt_valid  (arb_valid)
    );

    // last_grant starts at the top source so source 0 wins the first search
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            state      <= ST_IDLE;
            grant_idx  <= '0;
            last_grant <= IW'(NUM_SRC - 1);
            busy       <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (arb_valid) begin
                        state      <= ST_LOCKED;
                        grant_idx  <= arb_idx;
                        last_grant <= arb_idx;
                        busy       <= 1'b1;
                    end
                end
                ST_LOCKED: begin
                    if (m_TVALID && m_TREADY && m_TLAST) begin
                        state <= ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign locked = (state == ST_LOCKED);

    // Zero-latency pass-through from the owner; payload is forced to 0 whenever no beat is offered
    always_comb begin
        m_TVALID = locked & s_TVALID[grant_idx];
        s_TREADY = '0;
        if (locked) begin
            s_TREADY[grant_idx] = m_TREADY;
        end
        m_TDATA = '0;
        m_TSTRB = '0;
        m_TKEEP = '0;
        m_TLAST = 1'b0;
        m_TID   = '0;
        m_TDEST = '0;
        m_TUSER = '0;
        if (m_TVALID) begin
            m_TDATA = s_TDATA[grant_idx];
            m_TSTRB = s_TSTRB[grant_idx];
            m_TKEEP = s_TKEEP[grant_idx];
            m_TLAST = s_TLAST[grant_idx];
            m_TID   = s_TID[grant_idx];
            m_TDEST = s_TDEST[grant_idx];
            m_TUSER = s_TUSER[grant_idx];
        end
    end

endmodule

// File: tb/tb_axi4_stream_arbiter.sv
// tb/tb_axi4_stream_arbiter.sv - directed and randomized checks of the packet-locked stream arbiter
module tb_axi4_stream_arbiter;

    logic             ACLK = 1'b0;
    logic             ARESET;
    logic [3:0]       s_TVALID, s_TLAST, s_TREADY;
    logic [3:0][7:0]  s_TDATA;
    logic [3:0][0:0]  s_TSTRB, s_TKEEP, s_TID, s_TDEST, s_TUSER;
    logic             m_TVALID, m_TLAST, m_TREADY;
    logic [7:0]       m_TDATA;
    logic [0:0]       m_TSTRB, m_TKEEP, m_TID, m_TDEST, m_TUSER;
    logic [1:0]       grant_idx;
    logic             busy;

    axi4_stream_arbiter #(.NUM_SRC(4), .N(1), .I(1), .D(1), .U(1)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .s_TVALID(s_TVALID), .s_TLAST(s_TLAST), .s_TREADY(s_TREADY),
        .s_TDATA(s_TDATA), .s_TSTRB(s_TSTRB), .s_TKEEP(s_TKEEP),
        .s_TID(s_TID), .s_TDEST(s_TDEST), .s_TUSER(s_TUSER),
        .m_TVALID(m_TVALID), .m_TDATA(m_TDATA), .m_TSTRB(m_TSTRB), .m_TKEEP(m_TKEEP),
        .m_TLAST(m_TLAST), .m_TID(m_TID), .m_TDEST(m_TDEST), .m_TUSER(m_TUSER),
        .m_TREADY(m_TREADY), .grant_idx(grant_idx), .busy(busy)
    );

    always #5 ACLK = ~ACLK;

    typedef struct {
        logic       mv;
        logic       bz;
        logic [1:0] g;
        logic [7:0] d;
        logic       l;
        logic [3:0] rdy;
        logic       keep;
        logic       tid;
    } tr_t;

    tr_t         trace[$];
    logic [10:0] hs[$];
    logic [8:0]  srcq [4][$];
    logic [3:0]  gap;
    int          n_checks = 0;
    int          n_fail   = 0;

    function automatic logic [7:0] mk(input int s, input int p, input int b);
        return {2'(s), 2'(p), 4'(b)};
    endfunction

    task automatic load(input int s, input int p, input int nb);
        for (int b = 0; b < nb; b++) srcq[s].push_back({1'(b == nb - 1), mk(s, p, b)});
    endtask

    task automatic drive();
        for (int i = 0; i < 4; i++) begin
            logic [8:0] h;
            h = 9'h0;
            if (srcq[i].size() > 0) h = srcq[i][0];
            s_TVALID[i] = (srcq[i].size() > 0) && !gap[i];
            s_TDATA[i]  = h[7:0];
            s_TLAST[i]  = h[8];
            s_TSTRB[i]  = 1'b1;
            s_TKEEP[i]  = 1'b1;
            s_TID[i]    = 1'(i);
            s_TDEST[i]  = 1'(i >> 1);
            s_TUSER[i]  = h[0];
        end
    endtask

    // Sample mid-cycle, then advance each source that completed a handshake on the edge
    task automatic step();
        logic [3:0] fire;
        logic [8:0] junk;
        tr_t        t;
        @(negedge ACLK);
        fire   = s_TVALID & s_TREADY;
        t.mv   = m_TVALID;  t.bz  = busy;     t.g    = grant_idx; t.d   = m_TDATA;
        t.l    = m_TLAST;   t.rdy = s_TREADY; t.keep = m_TKEEP[0]; t.tid = m_TID[0];
        trace.push_back(t);
        if (m_TVALID && m_TREADY) hs.push_back({grant_idx, m_TLAST, m_TDATA});
        @(posedge ACLK);
        #1;
        for (int i = 0; i < 4; i++) if (fire[i] && srcq[i].size() > 0) junk = srcq[i].pop_front();
    endtask

    task automatic test_reset();
        trace.delete();
        ARESET = 1'b1; m_TREADY = 1'b1;
        srcq[1].push_back({1'b1, 8'h55});
        drive(); step(); step();
        for (int c = 0; c < 2; c++) begin
            n_checks++; if (trace[c].mv !== 1'b0) begin n_fail++; $display("FAIL reset_mvalid c=%0d got=%0b exp=0", c, trace[c].mv); end
            n_checks++; if (trace[c].bz !== 1'b0) begin n_fail++; $display("FAIL reset_busy c=%0d got=%0b exp=0", c, trace[c].bz); end
            n_checks++; if (trace[c].g !== 2'd0) begin n_fail++; $display("FAIL reset_grant c=%0d got=%0d exp=0", c, trace[c].g); end
            n_checks++; if (trace[c].rdy !== 4'h0) begin n_fail++; $display("FAIL reset_sready c=%0d got=%0h exp=0", c, trace[c].rdy); end
            n_checks++; if (trace[c].d !== 8'h0 || trace[c].l !== 1'b0) begin n_fail++; $display("FAIL reset_payload c=%0d got=%0h/%0b exp=0/0", c, trace[c].d, trace[c].l); end
        end
        srcq[1].delete();
        drive();
        ARESET = 1'b0;
        step();
        n_checks++; if (trace[2].bz !== 1'b0) begin n_fail++; $display("FAIL reset_release_idle got=%0b exp=0", trace[2].bz); end
    endtask

    task automatic test_round_robin();
        int ph, s, hs0;
        trace.delete(); hs0 = hs.size(); m_TREADY = 1'b1;
        for (int i = 0; i < 4; i++) load(i, 0, 3);
        for (int c = 0; c < 16; c++) begin drive(); step(); end
        for (int c = 0; c < 16; c++) begin
            ph = c % 4; s = c / 4;
            n_checks++; if (trace[c].mv !== (ph != 0)) begin n_fail++; $display("FAIL rr_mvalid c=%0d got=%0b exp=%0b", c, trace[c].mv, ph != 0); end
            n_checks++; if (trace[c].bz !== (ph != 0)) begin n_fail++; $display("FAIL rr_busy c=%0d got=%0b exp=%0b", c, trace[c].bz, ph != 0); end
            if (ph != 0) begin
                n_checks++; if (trace[c].g !== 2'(s)) begin n_fail++; $display("FAIL rr_grant c=%0d got=%0d exp=%0d", c, trace[c].g, s); end
                n_checks++; if (trace[c].d !== mk(s, 0, ph - 1)) begin n_fail++; $display("FAIL rr_data c=%0d got=%0h exp=%0h", c, trace[c].d, mk(s, 0, ph - 1)); end
                n_checks++; if (trace[c].l !== (ph == 3)) begin n_fail++; $display("FAIL rr_last c=%0d got=%0b exp=%0b", c, trace[c].l, ph == 3); end
                n_checks++; if (trace[c].rdy !== 4'(1 << s)) begin n_fail++; $display("FAIL rr_sready c=%0d got=%0h exp=%0h", c, trace[c].rdy, 4'(1 << s)); end
                n_checks++; if (trace[c].tid !== 1'(s) || trace[c].keep !== 1'b1) begin n_fail++; $display("FAIL rr_sideband c=%0d got=%0b/%0b exp=%0b/1", c, trace[c].tid, trace[c].keep, 1'(s)); end
            end else begin
                n_checks++; if (trace[c].d !== 8'h0 || trace[c].rdy !== 4'h0) begin n_fail++; $display("FAIL rr_bubble c=%0d got=%0h/%0h exp=0/0", c, trace[c].d, trace[c].rdy); end
            end
        end
        n_checks++; if (hs.size() - hs0 !== 12) begin n_fail++; $display("FAIL rr_beats got=%0d exp=12", hs.size() - hs0); end
    endtask

    task automatic test_back_to_back();
        logic [6:0] mvp;
        int pk, bt;
        mvp = 7'b0110110;
        trace.delete();
        load(2, 0, 2); load(2, 1, 2);
        for (int c = 0; c < 7; c++) begin drive(); step(); end
        for (int c = 0; c < 7; c++) begin
            pk = (c >= 4) ? 1 : 0; bt = (c - 1) % 3;
            n_checks++; if (trace[c].mv !== mvp[c]) begin n_fail++; $display("FAIL b2b_mvalid c=%0d got=%0b exp=%0b", c, trace[c].mv, mvp[c]); end
            n_checks++; if ((trace[c].rdy & 4'b1011) !== 4'h0) begin n_fail++; $display("FAIL b2b_other_ready c=%0d got=%0h exp=0", c, trace[c].rdy); end
            if (mvp[c]) begin
                n_checks++; if (trace[c].g !== 2'd2) begin n_fail++; $display("FAIL b2b_grant c=%0d got=%0d exp=2", c, trace[c].g); end
                n_checks++; if (trace[c].d !== mk(2, pk, bt)) begin n_fail++; $display("FAIL b2b_data c=%0d got=%0h exp=%0h", c, trace[c].d, mk(2, pk, bt)); end
            end
        end
    endtask

    task automatic test_gap();
        trace.delete();
        load(1, 0, 4);
        for (int c = 0; c < 13; c++) begin
            gap[1] = (c >= 2 && c <= 6);
            if (c == 1) load(3, 0, 2);
            drive(); step();
        end
        gap = 4'h0;
        n_checks++; if (trace[1].g !== 2'd1 || trace[1].d !== mk(1, 0, 0)) begin n_fail++; $display("FAIL gap_first got=%0d/%0h exp=1/%0h", trace[1].g, trace[1].d, mk(1, 0, 0)); end
        for (int c = 2; c <= 6; c++) begin
            n_checks++; if (trace[c].mv !== 1'b0 || trace[c].bz !== 1'b1 || trace[c].g !== 2'd1) begin n_fail++; $display("FAIL gap_hold c=%0d got=%0b/%0b/%0d exp=0/1/1", c, trace[c].mv, trace[c].bz, trace[c].g); end
        end
        for (int c = 1; c <= 9; c++) begin
            n_checks++; if (trace[c].rdy[3] !== 1'b0) begin n_fail++; $display("FAIL gap_src3_ready c=%0d got=%0b exp=0", c, trace[c].rdy[3]); end
        end
        for (int c = 7; c <= 9; c++) begin
            n_checks++; if (trace[c].mv !== 1'b1 || trace[c].g !== 2'd1 || trace[c].d !== mk(1, 0, c - 6)) begin n_fail++; $display("FAIL gap_resume c=%0d got=%0b/%0d/%0h exp=1/1/%0h", c, trace[c].mv, trace[c].g, trace[c].d, mk(1, 0, c - 6)); end
        end
        n_checks++; if (trace[10].bz !== 1'b0) begin n_fail++; $display("FAIL gap_bubble got=%0b exp=0", trace[10].bz); end
        n_checks++; if (trace[11].g !== 2'd3 || trace[11].d !== mk(3, 0, 0)) begin n_fail++; $display("FAIL gap_next_src got=%0d/%0h exp=3/%0h", trace[11].g, trace[11].d, mk(3, 0, 0)); end
        n_checks++; if (trace[12].l !== 1'b1 || trace[12].d !== mk(3, 0, 1)) begin n_fail++; $display("FAIL gap_next_last got=%0b/%0h exp=1/%0h", trace[12].l, trace[12].d, mk(3, 0, 1)); end
    endtask

    task automatic test_tlast_stall();
        int hs0;
        trace.delete(); hs0 = hs.size();
        load(0, 3, 2);
        for (int c = 0; c < 8; c++) begin
            m_TREADY = !(c >= 2 && c <= 5);
            drive(); step();
        end
        m_TREADY = 1'b1;
        for (int c = 2; c <= 6; c++) begin
            n_checks++; if (trace[c].bz !== 1'b1 || trace[c].g !== 2'd0) begin n_fail++; $display("FAIL stall_lock c=%0d got=%0b/%0d exp=1/0", c, trace[c].bz, trace[c].g); end
            n_checks++; if (trace[c].mv !== 1'b1 || trace[c].l !== 1'b1 || trace[c].d !== mk(0, 3, 1)) begin n_fail++; $display("FAIL stall_beat c=%0d got=%0b/%0b/%0h exp=1/1/%0h", c, trace[c].mv, trace[c].l, trace[c].d, mk(0, 3, 1)); end
        end
        n_checks++; if (trace[7].bz !== 1'b0) begin n_fail++; $display("FAIL stall_release got=%0b exp=0", trace[7].bz); end
        n_checks++; if (hs.size() - hs0 !== 2) begin n_fail++; $display("FAIL stall_beats got=%0d exp=2", hs.size() - hs0); end
    endtask

    task automatic test_reset_mid();
        trace.delete();
        load(3, 1, 4); load(0, 2, 1);
        for (int c = 0; c < 6; c++) begin
            if (c == 3) begin ARESET = 1'b0; srcq[3].delete(); end
            drive();
            if (c == 2) ARESET = 1'b1;
            step();
        end
        n_checks++; if (trace[1].g !== 2'd3 || trace[1].d !== mk(3, 1, 0)) begin n_fail++; $display("FAIL rmid_pre got=%0d/%0h exp=3/%0h", trace[1].g, trace[1].d, mk(3, 1, 0)); end
        n_checks++; if (trace[2].mv !== 1'b0 || trace[2].bz !== 1'b0 || trace[2].rdy !== 4'h0) begin n_fail++; $display("FAIL rmid_outputs got=%0b/%0b/%0h exp=0/0/0", trace[2].mv, trace[2].bz, trace[2].rdy); end
        n_checks++; if (trace[2].d !== 8'h0 || trace[2].g !== 2'd0) begin n_fail++; $display("FAIL rmid_payload got=%0h/%0d exp=0/0", trace[2].d, trace[2].g); end
        n_checks++; if (trace[3].bz !== 1'b0) begin n_fail++; $display("FAIL rmid_idle got=%0b exp=0", trace[3].bz); end
        n_checks++; if (trace[4].mv !== 1'b1 || trace[4].g !== 2'd0 || trace[4].d !== mk(0, 2, 0)) begin n_fail++; $display("FAIL rmid_next got=%0b/%0d/%0h exp=1/0/%0h", trace[4].mv, trace[4].g, trace[4].d, mk(0, 2, 0)); end
        n_checks++; if (trace[5].bz !== 1'b0) begin n_fail++; $display("FAIL rmid_done got=%0b exp=0", trace[5].bz); end
    endtask

    task automatic test_random();
        logic [7:0] expq [4][$];
        logic [7:0] e;
        logic [1:0] g, owner;
        logic       mid;
        int hs0, cyc, seq, pending;
        trace.delete(); hs0 = hs.size();
        for (int s = 0; s < 4; s++) begin
            seq = 0;
            for (int p = 0; p < 5; p++) begin
                int nb;
                nb = $urandom_range(1, 4);
                for (int b = 0; b < nb; b++) begin
                    e = {2'(s), 6'(seq)}; seq++;
                    srcq[s].push_back({1'(b == nb - 1), e});
                    expq[s].push_back(e);
                end
            end
        end
        cyc = 0; pending = 1;
        while (pending != 0 && cyc < 3000) begin
            for (int i = 0; i < 4; i++) gap[i] = ($urandom_range(0, 3) == 0);
            m_TREADY = ($urandom_range(0, 3) != 0);
            drive(); step(); cyc++;
            pending = 0;
            for (int i = 0; i < 4; i++) pending += srcq[i].size();
        end
        gap = 4'h0; m_TREADY = 1'b1; drive();
        n_checks++; if (pending != 0) begin n_fail++; $display("FAIL rand_timeout got=%0d beats pending exp=0", pending); end
        owner = 2'd0; mid = 1'b0;
        for (int k = hs0; k < hs.size(); k++) begin
            g = hs[k][10:9];
            n_checks++; if (mid && g !== owner) begin n_fail++; $display("FAIL rand_interleave beat=%0d got=src%0d exp=src%0d", k, g, owner); end
            owner = g; mid = !hs[k][8];
            e = (expq[g].size() > 0) ? expq[g].pop_front() : 8'hxx;
            n_checks++; if (hs[k][7:0] !== e) begin n_fail++; $display("FAIL rand_order beat=%0d src=%0d got=%0h exp=%0h", k, g, hs[k][7:0], e); end
        end
        for (int s = 0; s < 4; s++) begin
            n_checks++; if (expq[s].size() != 0) begin n_fail++; $display("FAIL rand_missing src=%0d got=%0d left exp=0", s, expq[s].size()); end
        end
    endtask

    initial begin
        ARESET = 1'b1; m_TREADY = 1'b1; gap = 4'h0;
        s_TVALID = '0; s_TLAST = '0; s_TDATA = '0; s_TSTRB = '0; s_TKEEP = '0;
        s_TID = '0; s_TDEST = '0; s_TUSER = '0;
        test_reset();
        test_round_robin();
        test_back_to_back();
        test_gap();
        test_tlast_stall();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

endmodule
